// File: rtl/itree_config_loader.sv
// Checksummed byte-stream loader for the isolation-tree image: assembles a shadow copy and commits
// it atomically on a good checksum. Optional inactivity abort under ITREE_LOADER_TIMEOUT_EN.
module itree_config_loader #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned IMG_W          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [IMG_W-1:0]  itree_input,
  output logic              load_itree,
  output logic              itree_valid,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int unsigned NBEATS = IMG_W / DATA_W;
  localparam int unsigned CNT_W  = $clog2(NBEATS) + 1;

  if ((IMG_W % DATA_W) != 0 || NBEATS < 2 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("itree_config_loader: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StRecv, StCksum} state_e;

  state_e             state_q, state_d;
  logic [IMG_W-1:0]   shadow_q, shadow_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic               img_valid_q, img_valid_d;
  logic               load_q, load_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               accept;
  logic [DATA_W-1:0]  total;

`ifdef ITREE_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    img_d       = img_q;
    count_d     = count_q;
    sum_d       = sum_q;
    img_valid_d = img_valid_q;
    load_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    cfg_ready   = 1'b0;
    cfg_busy    = 1'b0;
    accept      = 1'b0;
    total       = sum_q + cfg_data;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StRecv;
          count_d = '0;
          sum_d   = '0;
          error_d = 1'b0;
        end
      end
      StRecv: begin
        cfg_busy  = 1'b1;
        cfg_ready = !cfg_start;
        if (cfg_start) begin
          count_d = '0;
          sum_d   = '0;
          error_d = 1'b0;
        end else if (cfg_valid) begin
          accept   = 1'b1;
          // MSB-first: after NBEATS shifts the first beat sits in the top slot.
          shadow_d = {shadow_q[IMG_W-DATA_W-1:0], cfg_data};
          count_d  = count_q + CNT_W'(1);
          sum_d    = total;
          if (count_q == CNT_W'(NBEATS - 1)) state_d = StCksum;
        end
      end
      StCksum: begin
        cfg_busy  = 1'b1;
        cfg_ready = 1'b1;
        // A checksum beat wins over a simultaneous cfg_start.
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = StIdle;
          if (total == '0) begin
            img_d       = shadow_q;
            img_valid_d = 1'b1;
            load_d      = 1'b1;
            done_d      = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (cfg_start) begin
          state_d = StRecv;
          count_d = '0;
          sum_d   = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef ITREE_LOADER_TIMEOUT_EN
    idle_cnt_d = '0;
    if (state_q != StIdle && !accept && !cfg_start) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = StIdle;
        error_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      img_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      img_valid_q <= 1'b0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef ITREE_LOADER_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      img_q       <= img_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      img_valid_q <= img_valid_d;
      load_q      <= load_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef ITREE_LOADER_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign itree_input = img_q;
  assign itree_valid = img_valid_q;
  assign load_itree  = load_q;
  assign cfg_done    = done_q;
  assign cfg_error   = error_q;

endmodule
